keccak_plane_pipe: RTL and testbench
====================================

KECCAK_PLANE_PIPE -- requirements
Module: keccak_plane_pipe

Interface
REQ-001 The module SHALL have parameter LANE_W, default 64, giving lane width in bits; legal values are 8, 16, 32 and 64.
REQ-002 The module SHALL have parameter ROT, default 1, giving the theta left-rotate amount; legal range is 0..LANE_W-1.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The module SHALL have port rst_i, input, 1 bit: the asynchronous, active-high reset.
REQ-005 The module SHALL have port clear_i, input, 1 bit: synchronous abort of parity accumulation.
REQ-006 The module SHALL have port in_valid_i, input, 1 bit: input plane valid.
REQ-007 The module SHALL have port in_ready_o, output, 1 bit: input plane accepted.
REQ-008 The module SHALL have port op_i, input, 2 bits: 00 PARITY, 01 THETA, 10 CHI, 11 reserved.
REQ-009 The module SHALL have port plane_i, input, 5*LANE_W bits: lane x occupies bits [x*LANE_W +: LANE_W].
REQ-010 The module SHALL have port rc_i, input, LANE_W bits: round constant.
REQ-011 The module SHALL have port iota_i, input, 1 bit: apply rc_i in CHI.
REQ-012 The module SHALL have port out_valid_o, output, 1 bit: output plane valid.
REQ-013 The module SHALL have port out_ready_i, input, 1 bit: downstream accept.
REQ-014 The module SHALL have port plane_o, output, 5*LANE_W bits: result plane.
REQ-015 The module SHALL have port d_valid_o, output, 1 bit: the D register holds a complete theta term.
REQ-016 The module SHALL have port err_o, output, 1 bit: sticky error flag for reserved op or THETA without D.

Function
REQ-017 A transfer SHALL occur when in_valid_i and in_ready_o are both high; in_ready_o SHALL equal (!out_valid_o || out_ready_i) && !clear_i.
REQ-018 An output transfer SHALL occur when out_valid_o and out_ready_i are both high; plane_o SHALL be registered and held stable while out_valid_o is high and out_ready_i is low.
REQ-019 On a PARITY transfer, the column register C SHALL become C ^ plane_i, or plane_i when the 3-bit counter cnt is 0, and cnt SHALL increment; no output is produced for counts 0..3.
REQ-020 On the fifth PARITY transfer (cnt==4), the module SHALL store D[x] = C'[(x+4)%5] ^ rotl(C'[(x+1)%5], ROT) into D, where C' is the updated parity, and SHALL also present D on plane_o with out_valid_o on the next cycle. It SHALL then reset cnt to 0 and set d_valid_o.
REQ-021 On a THETA transfer, plane_o[x] SHALL become plane_i[x] ^ D[x] one cycle later; D and d_valid_o SHALL be unchanged.
REQ-022 On a CHI transfer, plane_o[x] SHALL become plane_i[x] ^ (~plane_i[(x+1)%5] & plane_i[(x+2)%5]) one cycle later.
REQ-023 Latency SHALL be exactly 1 cycle from the accepting edge to out_valid_o high for every output-producing transfer; sustained throughput SHALL be 1 plane per cycle with out_ready_i held high.
REQ-024 A PARITY transfer with cnt!=0 that is interleaved with a THETA or CHI transfer SHALL leave cnt and C unchanged by the THETA or CHI transfer.
REQ-025 A THETA transfer while d_valid_o is low, or any op 11 transfer, SHALL set err_o and SHALL produce an output of plane_i unchanged.
REQ-026 clear_i high SHALL zero cnt, C and d_valid_o, SHALL leave D, the output register and err_o untouched, and SHALL block acceptance that cycle.
REQ-027 A new PARITY sequence starting while d_valid_o is high SHALL keep the old D usable by THETA until the fifth plane overwrites it.

Reset
REQ-028 On rst_i, the module SHALL asynchronously clear out_valid_o, d_valid_o, err_o, cnt, C, D and plane_o to 0; in_ready_o SHALL be 1 after reset, with clear_i low.
REQ-029 Reset asserted mid-sequence SHALL discard the partial parity; the first PARITY transfer after reset SHALL be treated as cnt==0.

Configuration
REQ-030 With KECCAK_PLANE_IOTA_EN defined, a CHI transfer with iota_i high SHALL additionally XOR rc_i into lane 0 of the result.
REQ-031 Without KECCAK_PLANE_IOTA_EN, rc_i and iota_i SHALL be ignored and CHI output SHALL be pure chi.

Verification
REQ-032 The bench SHALL cover: LANE_W=64, five PARITY planes with lane x = 64'h1<<x, no stalls -> a single output after the 5th plane, D[x] = C[x-1]^rotl(C[x+1],1), d_valid_o=1.
REQ-033 The bench SHALL cover: CHI with plane_i all lanes 0 except lane 2 = all-ones -> plane_o lane 0 = all-ones, lane 2 = all-ones, others 0.
REQ-034 The bench SHALL cover: out_ready_i low for 3 cycles after a CHI output -> plane_o stable, in_ready_o=0, no second output until ready.
REQ-035 The bench SHALL cover: THETA right after reset -> err_o=1, plane_o=plane_i; after clear_i mid-PARITY at cnt==2 -> the next five PARITY planes produce correct D.
REQ-036 The bench SHALL cover: IOTA_EN defined, CHI of zero plane with iota_i=1 and rc_i=64'h8000000080008008 -> lane 0 = rc_i, other lanes 0.

Source files
------------

// File: rtl/keccak_plane_pipe.sv
// keccak_plane_pipe: one-plane-per-cycle Keccak theta/chi datapath with five-plane column parity.
// Define KECCAK_PLANE_IOTA_EN to fold the round constant into lane 0 of CHI results.
module keccak_plane_pipe #(
  parameter int LANE_W = 64,
  parameter int ROT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            op_i,
  input  logic [5*LANE_W-1:0]   plane_i,
  input  logic [LANE_W-1:0]     rc_i,
  input  logic                  iota_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [5*LANE_W-1:0]   plane_o,
  output logic                  d_valid_o,
  output logic                  err_o
);
  localparam int PW = 5 * LANE_W;
  localparam logic [1:0] OP_PAR = 2'b00;
  localparam logic [1:0] OP_THETA = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b11;
  logic [PW-1:0] r_c, r_d, r_plane, w_cn, w_d, w_theta, w_chi, w_chi_f, w_res;
  logic [2:0] r_cnt;
  logic r_out_valid, r_dv, r_err, w_xfer, w_out, w_bad;
  for (genvar x = 0; x < 5; x++) begin : g_lane
    localparam int XP = (x + 1) % 5;
    localparam int XQ = (x + 2) % 5;
    localparam int XN = (x + 4) % 5;
    logic [LANE_W-1:0] w_cp;
    assign w_cn[x*LANE_W +: LANE_W] = (r_cnt == 3'd0) ? plane_i[x*LANE_W +: LANE_W]
                                      : r_c[x*LANE_W +: LANE_W] ^ plane_i[x*LANE_W +: LANE_W];
    assign w_cp = w_cn[XP*LANE_W +: LANE_W];
    assign w_d[x*LANE_W +: LANE_W] = w_cn[XN*LANE_W +: LANE_W] ^ ((w_cp << ROT) | (w_cp >> (LANE_W - ROT)));
    assign w_theta[x*LANE_W +: LANE_W] = plane_i[x*LANE_W +: LANE_W] ^ r_d[x*LANE_W +: LANE_W];
    assign w_chi[x*LANE_W +: LANE_W] = plane_i[x*LANE_W +: LANE_W]
                                       ^ (~plane_i[XP*LANE_W +: LANE_W] & plane_i[XQ*LANE_W +: LANE_W]);
  end
`ifdef KECCAK_PLANE_IOTA_EN
  assign w_chi_f = w_chi ^ {{(PW-LANE_W){1'b0}}, {LANE_W{iota_i}} & rc_i};
`else
  logic w_unused;
  assign w_unused = ^{rc_i, iota_i};
  assign w_chi_f = w_chi;
`endif
  assign in_ready_o = (!r_out_valid || out_ready_i) && !clear_i;
  assign w_xfer = in_valid_i && in_ready_o;
  assign w_bad = (op_i == OP_RSV) || (op_i == OP_THETA && !r_dv);
  assign w_out = w_xfer && (op_i != OP_PAR || r_cnt == 3'd4);
  assign w_res = w_bad ? plane_i : (op_i == OP_PAR) ? w_d : (op_i == OP_THETA) ? w_theta : w_chi_f;
  assign out_valid_o = r_out_valid;
  assign plane_o = r_plane;
  assign d_valid_o = r_dv;
  assign err_o = r_err;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_c <= '0;
      r_d <= '0;
      r_plane <= '0;
      r_cnt <= '0;
      r_out_valid <= 1'b0;
      r_dv <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (clear_i) begin
        r_c <= '0;
        r_cnt <= '0;
        r_dv <= 1'b0;
      end else if (w_xfer && op_i == OP_PAR) begin
        r_c <= w_cn;
        r_cnt <= (r_cnt == 3'd4) ? 3'd0 : r_cnt + 3'd1;
        if (r_cnt == 3'd4) begin
          r_d <= w_d;
          r_dv <= 1'b1;
        end
      end
      if (w_xfer && w_bad) r_err <= 1'b1;
      if (w_out) begin
        r_plane <= w_res;
        r_out_valid <= 1'b1;
      end else if (out_ready_i) r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_keccak_plane_pipe.sv
// tb_keccak_plane_pipe: scoreboard bench for keccak_plane_pipe at LANE_W=64, ROT=1.
module tb_keccak_plane_pipe;
  localparam int W = 64;
  localparam int PW = 5 * W;
  logic clk_i = 0, rst_i = 0, clear_i = 0, in_valid_i = 0, out_ready_i = 1, iota_i = 0;
  logic [1:0] op_i = 0;
  logic [PW-1:0] plane_i = '0, plane_o;
  logic [W-1:0] rc_i = '0;
  logic in_ready_o, out_valid_o, d_valid_o, err_o;
  int n_run = 0, n_fail = 0, cyc = 0, n_push = 0, n_pop = 0;
  logic [PW-1:0] q[$];
  logic [W-1:0] mc[5], md[5];
  int mcnt = 0;
  logic mdv = 0, merr = 0;

  keccak_plane_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .op_i(op_i), .plane_i(plane_i), .rc_i(rc_i),
    .iota_i(iota_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .plane_o(plane_o), .d_valid_o(d_valid_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(input logic [W-1:0] l[5]);
    logic [PW-1:0] p;
    for (int x = 0; x < 5; x++) p[x*W +: W] = l[x];
    return p;
  endfunction

  function automatic logic [PW-1:0] chi_m(input logic [PW-1:0] p, input logic io, input logic [W-1:0] rc);
    logic [W-1:0] a[5], r[5];
    for (int x = 0; x < 5; x++) a[x] = p[x*W +: W];
    for (int x = 0; x < 5; x++) r[x] = a[x] ^ (~a[(x+1)%5] & a[(x+2)%5]);
`ifdef KECCAK_PLANE_IOTA_EN
    if (io) r[0] = r[0] ^ rc;
`endif
    return pack(r);
  endfunction

  task automatic model_reset();
    mcnt = 0; mdv = 0; merr = 0;
    for (int x = 0; x < 5; x++) begin mc[x] = '0; md[x] = '0; end
  endtask

  task automatic accept(input logic [1:0] op, input logic [PW-1:0] p, input logic io, input logic [W-1:0] rc);
    logic [W-1:0] a;
    logic [PW-1:0] e;
    if (op == 2'b00) begin
      for (int x = 0; x < 5; x++) mc[x] = (mcnt == 0) ? p[x*W +: W] : mc[x] ^ p[x*W +: W];
      if (mcnt == 4) begin
        for (int x = 0; x < 5; x++) begin
          a = mc[(x+1)%5];
          md[x] = mc[(x+4)%5] ^ {a[W-2:0], a[W-1]};
        end
        mdv = 1; mcnt = 0;
        q.push_back(pack(md)); n_push++;
      end else mcnt++;
    end else begin
      if (op == 2'b11 || (op == 2'b01 && !mdv)) begin e = p; merr = 1; end
      else if (op == 2'b01) e = p ^ pack(md);
      else e = chi_m(p, io, rc);
      q.push_back(e); n_push++;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [PW-1:0] p, input logic io, input logic [W-1:0] rc);
    int n = 0;
    op_i = op; plane_i = p; iota_i = io; rc_i = rc; in_valid_i = 1;
    @(negedge clk_i);
    while (!in_ready_o && n < 50) begin n++; @(negedge clk_i); end
    if (in_ready_o) accept(op, p, io, rc);
    else chk("accept_timeout", in_ready_o, 1);
    @(posedge clk_i); #1 in_valid_i = 0;
  endtask

  function automatic logic [PW-1:0] rnd();
    logic [PW-1:0] p;
    for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  always @(negedge clk_i) begin
    if (out_valid_o && out_ready_i) begin
      if (q.size() == 0) chk("unexpected_out", out_valid_o, 0);
      else begin chk("plane", plane_o, q.pop_front()); n_pop++; end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin n++; @(posedge clk_i); end
    chk("drain", q.size(), 0);
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_reset();
    #2 rst_i = 1;
    #1;
    q.delete();
    model_reset();
    chk("rst_ov", out_valid_o, 0);
    chk("rst_plane", plane_o, 0);
    chk("rst_dv", d_valid_o, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk_i); #1 rst_i = 0;
    chk("rst_ready", in_ready_o, 1);
  endtask

  initial begin
    logic [PW-1:0] p, hold;
    int t0;
    model_reset();
    pulse_reset();
    p = rnd();
    send(2'b01, p, 0, '0);
    drain();
    chk("theta_noD_err", err_o, 1);
    chk("theta_noD_plane", plane_o, p);
    for (int x = 0; x < 5; x++) p[x*W +: W] = 64'h1 << x;
    for (int k = 0; k < 5; k++) send(2'b00, p, 0, '0);
    drain();
    chk("par_dv", d_valid_o, 1);
    chk("par_d0", plane_o[W-1:0], 64'h14);
    chk("par_count", n_pop, 2);
    send(2'b01, rnd(), 0, '0);
    p = '0; p[2*W +: W] = '1;
    send(2'b10, p, 0, '0);
    drain();
    chk("chi_const", plane_o, {{(2*W){1'b0}}, {W{1'b1}}, {W{1'b0}}, {W{1'b1}}});
    out_ready_i = 0;
    p = rnd();
    send(2'b10, p, 0, '0);
    hold = chi_m(p, 0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_plane", plane_o, hold);
      chk("stall_ready", in_ready_o, 0);
      chk("stall_valid", out_valid_o, 1);
    end
    fork
      begin repeat (2) @(posedge clk_i); #1 out_ready_i = 1; end
      send(2'b10, rnd(), 0, '0);
    join
    drain();
    send(2'b00, rnd(), 0, '0);
    send(2'b00, rnd(), 0, '0);
    send(2'b10, rnd(), 0, '0);
    send(2'b01, rnd(), 0, '0);
    for (int k = 0; k < 3; k++) send(2'b00, rnd(), 0, '0);
    send(2'b01, rnd(), 0, '0);
    drain();
    send(2'b00, rnd(), 0, '0);
    send(2'b00, rnd(), 0, '0);
    clear_i = 1; in_valid_i = 1; op_i = 2'b00; plane_i = rnd();
    @(negedge clk_i);
    chk("clear_ready", in_ready_o, 0);
    @(posedge clk_i); #1 clear_i = 0; in_valid_i = 0;
    mcnt = 0; mdv = 0;
    chk("clear_dv", d_valid_o, 0);
    chk("clear_err", err_o, merr);
    for (int k = 0; k < 5; k++) send(2'b00, rnd(), 0, '0);
    send(2'b01, rnd(), 0, '0);
    send(2'b11, rnd(), 0, '0);
    drain();
    chk("rsv_err", err_o, 1);
    send(2'b00, rnd(), 0, '0);
    send(2'b00, rnd(), 0, '0);
    pulse_reset();
    for (int k = 0; k < 5; k++) send(2'b00, rnd(), 0, '0);
    drain();
    chk("rst_seq_dv", d_valid_o, 1);
    chk("rst_seq_err", err_o, 0);
    send(2'b10, '0, 1, 64'h8000000080008008);
    drain();
`ifdef KECCAK_PLANE_IOTA_EN
    chk("iota", plane_o, {{(PW-W){1'b0}}, 64'h8000000080008008});
`else
    chk("iota_off", plane_o, '0);
`endif
    t0 = cyc;
    for (int k = 0; k < 4; k++) send(2'b10, rnd(), k[0], 64'(k));
    chk("throughput", cyc - t0, 4);
    drain();
    chk("out_total", n_pop, n_push);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
